// File: rtl/fetch_pkg.sv
// fetch_pkg: shared state encoding, constants and IF/ID entry type for the fetch stage
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, FULL, HALT} fetch_state_t;
    localparam logic [4:0]  HALT_OPCODE = 5'b00000;
    localparam logic [15:0] DEFAULT_NOP = 16'h0800;
    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] pc_next;
        logic        valid;
        logic        is_halt;
    } ifid_t;
endpackage

// File: rtl/fetch_skid.sv
// fetch_skid: one-entry IF/ID holding buffer used while decode stalls
module fetch_skid
    import fetch_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  load_i,
    input  logic  drain_i,
    input  logic  flush_i,
    input  ifid_t data_i,
    output ifid_t data_o
);
    ifid_t skid_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) skid_q <= '0;
        else if (flush_i) skid_q <= '0;
        else if (load_i) skid_q <= data_i;
        else if (drain_i) skid_q <= '0;
    end
    assign data_o = skid_q;
endmodule

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: PC and imem handshake, IF/ID register with skid, redirect and HALT handling
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h0000,
    parameter logic [15:0] NOP_INSTR = DEFAULT_NOP
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect,
    input  logic [15:0] redirect_pc,
    input  logic        stall,
    output logic        imem_rd,
    output logic [15:0] imem_addr,
    input  logic [15:0] imem_data,
    input  logic        imem_done,
    output logic [15:0] instruction,
    output logic [15:0] pc_next,
    output logic        if_valid,
    output logic        halted,
    output logic        err
);
    fetch_state_t state_q, state_d;
    logic [15:0]  pc_q, pc_d, req_addr_q, req_addr_d;
    logic         drop_q, drop_d, err_q, err_d, halted_q;
    logic         skid_load, skid_drain, skid_flush;
    ifid_t        out_q, out_d, skid, word;

    assign word = '{instr: imem_data, pc_next: pc_q + 16'd2, valid: 1'b1,
                    is_halt: imem_data[15:11] == HALT_OPCODE};

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        drop_d     = drop_q;
        err_d      = err_q;
        out_d      = out_q;
        skid_load  = 1'b0;
        skid_drain = 1'b0;
        skid_flush = 1'b0;
        if (out_q.valid && !stall) begin
            out_d.valid = 1'b0;
            out_d.instr = NOP_INSTR;
        end
        if (redirect) begin
            pc_d        = redirect_pc;
            out_d.valid = 1'b0;
            out_d.instr = NOP_INSTR;
            skid_flush  = 1'b1;
            err_d       = err_q | redirect_pc[0];
            // an in-flight request keeps its address; its response is discarded
            drop_d      = state_q == FETCH && !imem_done && !redirect_pc[0];
            state_d     = redirect_pc[0] ? HALT : FETCH;
        end else begin
            case (state_q)
                IDLE: state_d = FETCH;
                FETCH: if (imem_done) begin
                    if (drop_q) drop_d = 1'b0;
                    else begin
                        pc_d = pc_q + 16'd2;
                        if (!out_q.valid || !stall) begin
                            out_d   = word;
                            state_d = word.is_halt ? HALT : FETCH;
                        end else begin
                            skid_load = 1'b1;
                            state_d   = FULL;
                        end
                    end
                end
                FULL: if (!stall) begin
                    out_d      = skid;
                    skid_drain = 1'b1;
                    state_d    = skid.is_halt ? HALT : FETCH;
                end
                default: state_d = state_q;
            endcase
        end
        req_addr_d = (state_q == FETCH && !imem_done) ? req_addr_q : pc_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_addr_q <= RESET_PC;
            drop_q     <= 1'b0;
            err_q      <= 1'b0;
            halted_q   <= 1'b0;
            out_q      <= '{instr: NOP_INSTR, pc_next: RESET_PC, valid: 1'b0, is_halt: 1'b0};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_addr_q <= req_addr_d;
            drop_q     <= drop_d;
            err_q      <= err_d;
            halted_q   <= state_d == HALT;
            out_q      <= out_d;
        end
    end

    fetch_skid u_skid (
        .clk    (clk),
        .rst    (rst),
        .load_i (skid_load),
        .drain_i(skid_drain),
        .flush_i(skid_flush),
        .data_i (word),
        .data_o (skid)
    );

    assign imem_rd     = state_q == FETCH;
    assign imem_addr   = req_addr_q;
    assign instruction = out_q.instr;
    assign pc_next     = out_q.pc_next;
    assign if_valid    = out_q.valid;
    assign halted      = halted_q;
    assign err         = err_q;
endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Instruction-fetch control stage sitting directly upstream of `decode`, which consumes its `instruction` and `pc_next` outputs. It owns the PC register and drives a multi-cycle (stalling) instruction memory through a Rd/Done handshake. It holds the IF/ID output register plus a one-entry skid buffer so `decode` can stall. It also handles PC redirects from the `memory` stage (branch/jump `newPC`) and stops fetching on HALT.

## Interface
Parameters:
- `RESET_PC`: default 16'h0000. PC loaded at reset.
- `NOP_INSTR`: default 16'h0800. Instruction presented while the output register is invalid.

Ports:
- `clk`: in, 1. Single clock, rising edge.
- `rst`: in, 1. Asynchronous, active-high reset.
- `redirect`: in, 1. Resolved branch/jump taken; load `redirect_pc`.
- `redirect_pc`: in, 16. Target PC.
- `stall`: in, 1. `decode` cannot accept; hold the output register.
- `imem_rd`: out, 1. Read request, held high until `imem_done`.
- `imem_addr`: out, 16. Request address, stable while `imem_rd`.
- `imem_data`: in, 16. Fetched word, valid when `imem_done`.
- `imem_done`: in, 1. One-cycle completion pulse. May coincide with the first `imem_rd` cycle.
- `instruction`: out, 16. IF/ID instruction.
- `pc_next`: out, 16. Address of `instruction` + 2.
- `if_valid`: out, 1. `instruction` is real.
- `halted`: out, 1. Fetch stopped.
- `err`: out, 1. Sticky; misaligned (odd) redirect target.

## Operation
- Consumption: `decode` takes the output register on any cycle with `if_valid & !stall`.
- State machine states: IDLE, FETCH, FULL, HALT.
- IDLE: entered only from reset. Unconditionally goes to FETCH next cycle. `imem_rd`=0.
- FETCH: `imem_rd`=1, `imem_addr`=`req_addr`. On `imem_done` with no redirect and no `drop` flag:
  - `pc`+=2. The next request goes to the new `pc`.
  - If the output slot is free (`!if_valid || !stall`), the word loads the output register and `if_valid`=1.
  - Otherwise the word loads the skid and the state goes to FULL.
- HALT detection: a fetched word with `[15:11]`=5'b00000 is HALT.
  - After it is placed in the output register, go to HALT.
  - If it is placed in the skid, go to FULL with its halt flag set.
- FULL: `imem_rd`=0. When `!stall`, the skid moves to the output register. Next state is HALT if the skid's halt flag is set, otherwise FETCH.
- HALT: `imem_rd`=0, `halted`=1. The output register still drains normally. Only `redirect` or `rst` leaves this state.
- Redirect has highest priority, in any state, and overrides `stall`:
  - `pc`←`redirect_pc`; output register and skid are invalidated (`if_valid`=0, `instruction`=`NOP_INSTR`); `halted`←0; state→FETCH.
  - If a request is outstanding (FETCH, no `imem_done` this cycle), set `drop`. `imem_rd`/`imem_addr` stay on the old `req_addr` until `imem_done`. That response is discarded, `drop` clears, and the next request uses the new `pc`.
  - If `imem_done` coincides with `redirect`, its data is discarded and `drop` is not set.
- Misaligned target: a redirect with `redirect_pc[0]`=1 sets `err` and goes to HALT instead of FETCH. `err` holds until reset.
- Arithmetic: 16-bit; PC+2 wraps 16'hFFFE→16'h0000 silently.

## Timing
- Reset values: `pc`=`req_addr`=`RESET_PC`; `instruction`=`NOP_INSTR`; `pc_next`=`RESET_PC`; `if_valid`=0; `halted`=0; `err`=0; `drop`=0; skid invalid; state=IDLE; `imem_rd`=0.
- Output logic: `imem_rd`/`imem_addr` are Moore outputs (state and `req_addr` only); no combinational path from `imem_done`. All other outputs are registered.
- Latency: the word is visible on `instruction` the cycle after `imem_done`.
- Throughput: if `imem_done` arrives in the first `imem_rd` cycle, throughput is 1 instruction/cycle. The first request after reset is issued in cycle 2.
- `req_addr` updates only on cycles when a new request starts (FETCH entry, or after `imem_done`).
- Reset mid-transaction: everything returns to reset values immediately. Any later `imem_done` from the aborted access is ignored because state is IDLE.

## Structure
- Package `fetch_pkg` holds:
  - state enum `fetch_state_t`;
  - `HALT_OPCODE`=5'b00000;
  - default `NOP_INSTR`;
  - typedef `ifid_t` {`instr`, `pc_next`, `valid`, `is_halt`}, used by both the output register and the skid.
- Sub-module `fetch_skid`: one-entry `ifid_t` buffer with load/drain/flush controls.

## Test plan
- Reset, then `imem_done` in the same cycle as every `imem_rd`, with words 16'hc1ff, 16'hc2f0 → `imem_addr` 0,2,4; `instruction` c1ff then c2f0 on consecutive cycles; `pc_next` 2,4.
- `stall`=1 for 3 cycles while words keep arriving → second word lands in the skid; `imem_rd`=0 in FULL; after `stall` drops the order is preserved and nothing is lost or duplicated.
- `redirect`=1, `redirect_pc`=16'h0040 while a request to 16'h0006 is outstanding → that response is discarded, the next `imem_addr` is 16'h0040, and `if_valid`=0 in between.
- Fetch 16'h0000 at 16'h0010 → `halted`=1, `imem_rd` stays 0; then `redirect` to 16'h0020 → fetch resumes at 16'h0020 and `halted`=0.
- `redirect_pc`=16'h0013 → `err`=1, `halted`=1, and `err` persists until `rst`.
- Assert `rst` mid-FETCH → same cycle: `imem_rd`=0, `if_valid`=0, `instruction`=16'h0800; restart at `RESET_PC`.
